// File: rtl/display_pkg.sv
// display_pkg: shared bank codes, queued-write record and EBI synchronizer depth
// for the display driver's host write path.
package display_pkg;
    typedef enum logic [2:0] {
        OAM     = 3'd0,
        TAM     = 3'd1,
        SPRITE  = 3'd2,
        PALETTE = 3'd3,
        CTRL    = 3'd4
    } bank_e;

    typedef struct packed {
        bank_e       bank;
        logic [15:0] addr;
        logic [15:0] data;
    } ebi_wr_t;

    localparam int EBI_SYNC_STAGES = 2;
endpackage

// File: rtl/ebi_write_fifo.sv
// ebi_write_fifo: in-order queue of host writes; an extra pointer bit separates
// full from empty so the level can reach DEPTH.
module ebi_write_fifo
    import display_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  ebi_wr_t                  din_i,
    input  logic                     pop_i,
    output ebi_wr_t                  dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wptr_q, rptr_q;
    ebi_wr_t     mem_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push_i) wptr_q <= wptr_q + 1'b1;
            if (pop_i)  rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wptr_q[AW-1:0]] <= din_i;
    end

    assign dout_o  = mem_q[rptr_q[AW-1:0]];
    assign empty_o = wptr_q == rptr_q;
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign level_o = wptr_q - rptr_q;
endmodule

// File: rtl/ebi_vram_write_scheduler.sv
// ebi_vram_write_scheduler: decodes multiplexed EBI write cycles, queues them and
// releases each to its video-memory bank only when the renderer allows it.
module ebi_vram_write_scheduler
    import display_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int NUM_BANKS   = 5,
    parameter int OAM_BANK    = 0,
    parameter int SYNC_STAGES = EBI_SYNC_STAGES
) (
    input  logic                          clk_100m,
    input  logic                          btn_rst,
    input  logic [15:0]                   EBI_AD,
    input  logic                          EBI_ALE,
    input  logic                          EBI_WE,
    input  logic                          EBI_RE,
    input  logic [2:0]                    bank_select,
    input  logic                          vblank,
    input  logic [7:0]                    bank_busy,
    output logic [7:0]                    wr_en,
    output logic [15:0]                   wr_addr,
    output logic [15:0]                   wr_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          bad_bank
);
    typedef enum logic [1:0] {IDLE, ADDR, ARMED, DATA} state_e;

    logic [SYNC_STAGES-1:0][2:0]  ctl_sync_q;
    logic [SYNC_STAGES-1:0][18:0] dat_sync_q;
    logic        ale_s, we_s, unused_re;
    logic [2:0]  bank_s;
    logic [15:0] ad_s;

    // Strobes idle high, so their synchronizers reset high to avoid a false edge.
    always_ff @(posedge clk_100m or negedge btn_rst) begin
        if (!btn_rst) begin
            ctl_sync_q <= '1;
            dat_sync_q <= '0;
        end else begin
            ctl_sync_q <= {ctl_sync_q[SYNC_STAGES-2:0], {EBI_ALE, EBI_WE, EBI_RE}};
            dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], {bank_select, EBI_AD}};
        end
    end

    assign {ale_s, we_s, unused_re} = ctl_sync_q[SYNC_STAGES-1];
    assign {bank_s, ad_s}           = dat_sync_q[SYNC_STAGES-1];

    state_e      state_q;
    logic        ale_q, we_q, overflow_q, bad_bank_q;
    logic [15:0] addr_q, wr_addr_q, wr_data_q;
    logic [7:0]  wr_en_q;
    logic        ale_fall, ale_rise, we_fall, we_rise;
    logic        push_req, bank_ok, push, pop, full, empty;
    ebi_wr_t     din, head;

    assign ale_fall = ale_q & ~ale_s;
    assign ale_rise = ~ale_q & ale_s;
    assign we_fall  = we_q & ~we_s;
    assign we_rise  = ~we_q & we_s;
    assign push_req = (state_q == DATA) && we_rise;
    assign bank_ok  = int'(bank_s) < NUM_BANKS;
    assign pop      = !empty && !bank_busy[head.bank] && (int'(head.bank) != OAM_BANK || vblank);
    assign push     = push_req && bank_ok && (!full || pop);
    assign din      = '{bank: bank_e'(bank_s), addr: addr_q, data: ad_s};

    ebi_write_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (clk_100m),
        .rst_ni  (btn_rst),
        .push_i  (push),
        .din_i   (din),
        .pop_i   (pop),
        .dout_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .level_o (fifo_level)
    );

    always_ff @(posedge clk_100m or negedge btn_rst) begin
        if (!btn_rst) begin
            state_q    <= IDLE;
            ale_q      <= 1'b1;
            we_q       <= 1'b1;
            addr_q     <= '0;
            wr_en_q    <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            overflow_q <= 1'b0;
            bad_bank_q <= 1'b0;
        end else begin
            ale_q <= ale_s;
            we_q  <= we_s;
            case (state_q)
                IDLE:  if (ale_fall) state_q <= ADDR;
                ADDR:  if (ale_rise) begin
                           addr_q  <= ad_s;
                           state_q <= ARMED;
                       end
                ARMED: if (we_fall) state_q <= DATA;
                       else if (ale_fall) state_q <= ADDR;
                DATA:  if (we_rise) state_q <= IDLE;
            endcase
            wr_en_q <= pop ? (8'd1 << head.bank) : 8'd0;
            if (pop) begin
                wr_addr_q <= head.addr;
                wr_data_q <= head.data;
            end
            if (push_req && !bank_ok) bad_bank_q <= 1'b1;
            if (push_req && bank_ok && full && !pop) overflow_q <= 1'b1;
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign overflow = overflow_q;
    assign bad_bank = bad_bank_q;
endmodule

// File: tb/tb_ebi_vram_write_scheduler.sv
// tb_ebi_vram_write_scheduler: table-driven single writes plus directed sequences
// for vblank gating, in-order blocking, overflow, bad bank and reset mid-access.
module tb_ebi_vram_write_scheduler;
    logic        clk = 1'b0;
    logic        btn_rst;
    logic [15:0] EBI_AD;
    logic        EBI_ALE, EBI_WE, EBI_RE;
    logic [2:0]  bank_select;
    logic        vblank;
    logic [7:0]  bank_busy;
    logic [7:0]  wr_en;
    logic [15:0] wr_addr, wr_data;
    logic [3:0]  fifo_level;
    logic        overflow, bad_bank;

    ebi_vram_write_scheduler dut (
        .clk_100m    (clk),
        .btn_rst     (btn_rst),
        .EBI_AD      (EBI_AD),
        .EBI_ALE     (EBI_ALE),
        .EBI_WE      (EBI_WE),
        .EBI_RE      (EBI_RE),
        .bank_select (bank_select),
        .vblank      (vblank),
        .bank_busy   (bank_busy),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .fifo_level  (fifo_level),
        .overflow    (overflow),
        .bad_bank    (bad_bank)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    logic [7:0]  en_q[$];
    logic [15:0] a_q[$];
    logic [15:0] d_q[$];
    int          t_q[$];

    always @(negedge clk) begin
        cyc++;
        if (wr_en != 8'd0) begin
            en_q.push_back(wr_en);
            a_q.push_back(wr_addr);
            d_q.push_back(wr_data);
            t_q.push_back(cyc);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic clear_log();
        en_q.delete();
        a_q.delete();
        d_q.delete();
        t_q.delete();
    endtask

    task automatic ebi_wr(input logic [2:0] b, input logic [15:0] a, input logic [15:0] d);
        bank_select = b;
        EBI_AD      = a;
        EBI_ALE     = 1'b0;
        repeat (4) @(negedge clk);
        EBI_ALE = 1'b1;
        repeat (4) @(negedge clk);
        EBI_AD = d;
        EBI_WE = 1'b0;
        repeat (4) @(negedge clk);
        EBI_WE = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    typedef struct {
        logic [2:0]  bank;
        logic [15:0] addr;
        logic [15:0] data;
        int          exp_n;
        logic [7:0]  exp_en;
        logic        exp_bad;
    } vec_t;

    vec_t vt[8];

    initial begin
        int bad;
        int lat;
        logic [15:0] last_addr;
        logic [15:0] last_data;
        vt[0] = '{3'd1, 16'h0123, 16'hBEEF, 1, 8'h02, 1'b0};
        vt[1] = '{3'd0, 16'h0004, 16'h1111, 1, 8'h01, 1'b0};
        vt[2] = '{3'd2, 16'hA5A5, 16'h2222, 1, 8'h04, 1'b0};
        vt[3] = '{3'd3, 16'h00FF, 16'h3333, 1, 8'h08, 1'b0};
        vt[4] = '{3'd4, 16'hFFFE, 16'h4444, 1, 8'h10, 1'b0};
        vt[5] = '{3'd6, 16'h1234, 16'h5555, 0, 8'h00, 1'b1};
        vt[6] = '{3'd5, 16'h4321, 16'h6666, 0, 8'h00, 1'b1};
        vt[7] = '{3'd1, 16'h0777, 16'h7777, 1, 8'h02, 1'b1};

        btn_rst = 1'b0; EBI_AD = '0; EBI_ALE = 1'b1; EBI_WE = 1'b1; EBI_RE = 1'b1;
        bank_select = '0; vblank = 1'b1; bank_busy = '0;
        repeat (3) @(negedge clk);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_bad_bank", bad_bank, 0);
        btn_rst = 1'b1;
        repeat (3) @(negedge clk);

        last_addr = 16'h0000;
        last_data = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            clear_log();
            ebi_wr(vt[i].bank, vt[i].addr, vt[i].data);
            repeat (6) @(negedge clk);
            chk($sformatf("v%0d_pulses", i), en_q.size(), vt[i].exp_n);
            if (vt[i].exp_n == 1 && en_q.size() == 1) begin
                chk($sformatf("v%0d_wr_en", i), en_q[0], vt[i].exp_en);
                chk($sformatf("v%0d_wr_addr", i), a_q[0], vt[i].addr);
                chk($sformatf("v%0d_wr_data", i), d_q[0], vt[i].data);
                last_addr = vt[i].addr;
                last_data = vt[i].data;
            end else begin
                chk($sformatf("v%0d_hold_addr", i), wr_addr, last_addr);
                chk($sformatf("v%0d_hold_data", i), wr_data, last_data);
            end
            chk($sformatf("v%0d_level", i), fifo_level, 0);
            chk($sformatf("v%0d_bad_bank", i), bad_bank, vt[i].exp_bad);
        end

        // OAM write held off until vblank
        vblank = 1'b0;
        clear_log();
        ebi_wr(3'd0, 16'h0004, 16'h55AA);
        bad = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (fifo_level !== 4'd1) bad++;
        end
        chk("oam_level_held", bad, 0);
        chk("oam_no_pulse", en_q.size(), 0);
        vblank = 1'b1;
        lat = 0;
        for (int k = 1; k <= 4 && lat == 0; k++) begin
            @(negedge clk);
            if (wr_en != 8'd0) lat = k;
        end
        chk("oam_latency_ok", (lat >= 1 && lat <= 2) ? 1 : 0, 1);
        repeat (4) @(negedge clk);
        chk("oam_pulses", en_q.size(), 1);
        chk("oam_wr_en", en_q.size() > 0 ? en_q[0] : 8'h00, 8'h01);
        chk("oam_wr_data", d_q.size() > 0 ? d_q[0] : 16'h0, 16'h55AA);
        chk("oam_level_after", fifo_level, 0);

        // blocked OAM head keeps a younger palette write waiting
        vblank = 1'b0;
        clear_log();
        ebi_wr(3'd0, 16'h0010, 16'hA0A0);
        ebi_wr(3'd3, 16'h0020, 16'hB0B0);
        repeat (20) @(negedge clk);
        chk("order_no_pulse", en_q.size(), 0);
        chk("order_level", fifo_level, 2);
        vblank = 1'b1;
        repeat (6) @(negedge clk);
        chk("order_pulses", en_q.size(), 2);
        if (en_q.size() == 2) begin
            chk("order_first_en", en_q[0], 8'h01);
            chk("order_second_en", en_q[1], 8'h08);
            chk("order_second_addr", a_q[1], 16'h0020);
            chk("order_consecutive", t_q[1] - t_q[0], 1);
        end

        // fill past capacity behind a busy sprite bank
        clear_log();
        bank_busy = 8'h04;
        for (int i = 0; i < 9; i++) ebi_wr(3'd2, 16'(i + 16'h0100), 16'(i));
        repeat (4) @(negedge clk);
        chk("ovf_level_full", fifo_level, 8);
        chk("ovf_flag", overflow, 1);
        chk("ovf_no_pulse", en_q.size(), 0);
        bank_busy = 8'h00;
        repeat (15) @(negedge clk);
        chk("ovf_drain_pulses", en_q.size(), 8);
        bad = 0;
        for (int i = 0; i < en_q.size(); i++)
            if (d_q[i] !== 16'(i) || en_q[i] !== 8'h04 || t_q[i] - t_q[0] != i) bad++;
        chk("ovf_drain_order", bad, 0);
        chk("ovf_level_empty", fifo_level, 0);
        chk("ovf_sticky", overflow, 1);

        // reset while a fourth access is in its data phase
        bank_busy = 8'h02;
        for (int i = 0; i < 3; i++) ebi_wr(3'd1, 16'h0200, 16'(16'hC000 + i));
        repeat (4) @(negedge clk);
        chk("mid_level_pre", fifo_level, 3);
        bank_select = 3'd1;
        EBI_AD = 16'h0300;
        EBI_ALE = 1'b0;
        repeat (4) @(negedge clk);
        EBI_ALE = 1'b1;
        repeat (4) @(negedge clk);
        EBI_AD = 16'hD00D;
        EBI_WE = 1'b0;
        repeat (4) @(negedge clk);
        btn_rst = 1'b0;
        #1;
        chk("mid_rst_wr_en", wr_en, 0);
        chk("mid_rst_addr", wr_addr, 0);
        chk("mid_rst_data", wr_data, 0);
        chk("mid_rst_level", fifo_level, 0);
        chk("mid_rst_flags", {overflow, bad_bank}, 0);
        repeat (3) @(negedge clk);
        btn_rst = 1'b1;
        bank_busy = 8'h00;
        clear_log();
        repeat (3) @(negedge clk);
        EBI_WE = 1'b1;
        repeat (12) @(negedge clk);
        chk("mid_no_stale_pulse", en_q.size(), 0);
        chk("mid_level_post", fifo_level, 0);
        ebi_wr(3'd1, 16'h0400, 16'hFACE);
        repeat (6) @(negedge clk);
        chk("mid_new_pulses", en_q.size(), 1);
        chk("mid_new_addr", a_q.size() > 0 ? a_q[0] : 16'h0, 16'h0400);
        chk("mid_new_data", d_q.size() > 0 ? d_q[0] : 16'h0, 16'hFACE);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
